grid_plotter: RTL and testbench
===============================

// Module: grid_plotter
// PURPOSE
//  Transmit side of the VGA plot-stream interface (VGA_X/VGA_Y/VGA_PLOT/VGA_COLOUR).
//  On a start pulse, sweeps the board-state RAM (1 bit per cell, row-major) once and
//  emits one pixel-plot command per cell. Consumed by the VGA adapter on hardware and
//  by the ASCII screen model in simulation. Sits between the life-update engine and the VGA port.
// PARAMETERS
//  X_SCREEN      49      max x index; row width = X_SCREEN+1
//  Y_SCREEN      49      max y index; rows = Y_SCREEN+1
//  ADDR_W        12      board RAM address width; (X_SCREEN+1)*(Y_SCREEN+1) <= 2**ADDR_W
//  ALIVE_COLOUR  3'b111  colour for live cells
//  DEAD_COLOUR   3'b000  colour for dead cells (used only with PLOT_DEAD_EN)
// PORTS
//  CLOCK_50    in   1       system clock, all logic on posedge
//  rst         in   1       synchronous reset, active-high
//  start       in   1       sweep request, sampled only when busy=0
//  hold        in   1       stall: freezes sweep, suppresses plot
//  mem_addr    out  ADDR_W  board RAM read address, y*(X_SCREEN+1)+x
//  mem_rdata   in   1       cell state, valid 1 cycle after mem_addr (sync RAM)
//  VGA_X       out  8       plot x coordinate
//  VGA_Y       out  7       plot y coordinate
//  VGA_PLOT    out  1       plot strobe, one pixel per high cycle
//  VGA_COLOUR  out  3       plot colour
//  busy        out  1       sweep in progress
//  done        out  1       one-cycle pulse at sweep completion
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, mem_addr=0, VGA_X=0, VGA_Y=0,
//    VGA_PLOT=0, VGA_COLOUR=0, busy=0, done=0, counters cleared.
//  - States: IDLE -> SWEEP on start (busy=0); SWEEP -> FLUSH after last address issued;
//    FLUSH -> IDLE after last plot, pulsing done. start while busy=1 ignored.
//  - C = (X_SCREEN+1)*(Y_SCREEN+1). start sampled at edge N: busy<=1, mem_addr<=0.
//    Address k issued at edge N+k; its plot presented at edge N+k+2 (2-cycle latency).
//    Last plot at edge N+C+1; at edge N+C+2: done<=1, busy<=0, VGA_PLOT<=0.
//    Sweep with no hold: busy high exactly C+2 cycles.
//  - Scan: x increments 0..X_SCREEN; at X_SCREEN, x wraps to 0 and y increments.
//    After (X_SCREEN,Y_SCREEN) no further addresses are issued.
//  - Coordinates pipelined alongside the address so VGA_X/VGA_Y match the mem_rdata cell.
//  - VGA_PLOT low whenever no valid cell is in the output stage.
//  - hold=1 at an edge: address counter, coordinate pipeline and FSM frozen; VGA_PLOT<=0.
//    On release the sweep resumes with no dropped or duplicated cell;
//    done is delayed by exactly the number of held cycles. hold in IDLE has no effect.
//  - rst mid-sweep: immediate return to reset values; no done pulse; next start restarts at (0,0).
//  - done and a new start in the same cycle: start ignored (busy was 1 at that edge).
//  - VGA_X/VGA_Y zero-extended from internal counters.
// CONFIGURATION
//  PLOT_DEAD_EN undefined (default): VGA_PLOT=1 only for live cells (mem_rdata=1),
//    colour ALIVE_COLOUR. Dead cells produce no plot.
//  PLOT_DEAD_EN defined: every cell plotted. Colour ALIVE_COLOUR if live, DEAD_COLOUR if dead.
//    Screen is fully repainted without a separate clear. Timing identical in both modes.
// TESTING
//  1. rst, all-zero RAM, start at edge N -> 0 plots; done pulse at edge N+2502; busy high 2502 cycles.
//  2. Glider at (1,0),(2,1),(0,2),(1,2),(2,2) -> exactly 5 plots at those coords, colour 3'b111, in scan order.
//     With PLOT_DEAD_EN: 2500 plots, 5 with 3'b111, 2495 with 3'b000.
//  3. Live cells at (49,0) and (0,1) -> plots on consecutive cycles, (49,0) then (0,1); row wrap correct.
//  4. hold high for 10 cycles mid-sweep -> no VGA_PLOT during hold; done at N+2512; set of plotted cells unchanged.
//  5. start pulsed while busy, and in the same cycle as done -> ignored; exactly one sweep/done per accepted start.
//  6. rst asserted at edge N+1000 -> next cycle all outputs 0, no done; new start sweeps from (0,0) with full timing.

Source files
------------

// File: rtl/grid_plotter_if.sv
`default_nettype none
// ============================================================================
//  Module      : grid_plotter_if
//  Description : Bundle of the plotter's control, board-RAM read port and
//                VGA plot-stream signals. The master side is the plotter,
//                the slave side is its environment (controller, RAM, VGA).
//  Revision    : 1.0  initial release
// ============================================================================
interface grid_plotter_if #(
    parameter int ADDR_W = 12
) ();
    logic              start;
    logic              hold;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rdata;
    logic [7:0]        VGA_X;
    logic [6:0]        VGA_Y;
    logic              VGA_PLOT;
    logic [2:0]        VGA_COLOUR;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        input  hold,
        input  mem_rdata,
        output mem_addr,
        output VGA_X,
        output VGA_Y,
        output VGA_PLOT,
        output VGA_COLOUR,
        output busy,
        output done
    );

    modport slave (
        output start,
        output hold,
        output mem_rdata,
        input  mem_addr,
        input  VGA_X,
        input  VGA_Y,
        input  VGA_PLOT,
        input  VGA_COLOUR,
        input  busy,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/grid_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : grid_plotter
//  Description : On a start pulse, sweeps the 1-bit-per-cell board RAM once in
//                row-major order and emits one VGA plot command per cell.
//                Address k leaves at edge N+k, its plot appears at N+k+2.
//                hold freezes the whole sweep without losing or repeating a
//                cell.
//  Options     : `define PLOT_DEAD_EN to plot dead cells too (DEAD_COLOUR),
//                giving a full repaint; otherwise only live cells are plotted.
//  Revision    : 1.0  initial release
// ============================================================================
module grid_plotter #(
    parameter int         X_SCREEN     = 49,
    parameter int         Y_SCREEN     = 49,
    parameter int         ADDR_W       = 12,
    parameter logic [2:0] ALIVE_COLOUR = 3'b111,
    parameter logic [2:0] DEAD_COLOUR  = 3'b000
) (
    input  wire logic      CLOCK_50,
    input  wire logic      rst,
    grid_plotter_if.master bus
);
    // Counter widths; a single-column/row screen still needs one bit.
    localparam int c_XW = (X_SCREEN > 0) ? $clog2(X_SCREEN + 1) : 1;
    localparam int c_YW = (Y_SCREEN > 0) ? $clog2(Y_SCREEN + 1) : 1;
    localparam logic [c_XW-1:0] c_X_MAX = c_XW'(X_SCREEN);
    localparam logic [c_YW-1:0] c_Y_MAX = c_YW'(Y_SCREEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    // Stage a: coordinates of the address currently on mem_addr.
    logic [c_XW-1:0]   r_x_a;
    logic [c_YW-1:0]   r_y_a;
    // Stage b: coordinates of the cell whose data is on mem_rdata.
    logic [c_XW-1:0]   r_x_b;
    logic [c_YW-1:0]   r_y_b;
    logic              r_vld_b;
    // While held the RAM keeps re-reading mem_addr, which is one cell ahead
    // of stage b, so stage b's data is captured on the first held edge and
    // replayed on release.
    logic              r_hold_d;
    logic              r_cell_sav;
    logic              r_plot;
    logic [7:0]        r_vga_x;
    logic [6:0]        r_vga_y;
    logic [2:0]        r_colour;

    logic              w_frozen;
    logic              w_cell;
    logic              w_plot;
    logic [2:0]        w_colour;
    logic              w_last;

    assign w_frozen = bus.hold && (r_state != ST_IDLE);
    assign w_cell   = r_hold_d ? r_cell_sav : bus.mem_rdata;
    assign w_colour = w_cell ? ALIVE_COLOUR : DEAD_COLOUR;
    assign w_last   = (r_x_a == c_X_MAX) && (r_y_a == c_Y_MAX);

`ifdef PLOT_DEAD_EN
    assign w_plot = r_vld_b;
`else
    assign w_plot = r_vld_b & w_cell;
`endif

    // Sweep FSM, address/coordinate pipeline and registered plot outputs.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addr     <= '0;
            r_x_a      <= '0;
            r_y_a      <= '0;
            r_x_b      <= '0;
            r_y_b      <= '0;
            r_vld_b    <= 1'b0;
            r_hold_d   <= 1'b0;
            r_cell_sav <= 1'b0;
            r_plot     <= 1'b0;
            r_vga_x    <= '0;
            r_vga_y    <= '0;
            r_colour   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_hold_d   <= w_frozen;
            r_cell_sav <= w_cell;
            if (w_frozen) begin
                r_plot <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_plot  <= 1'b0;
                        r_vld_b <= 1'b0;
                        if (bus.start) begin
                            r_state <= ST_SWEEP;
                            r_busy  <= 1'b1;
                            r_addr  <= '0;
                            r_x_a   <= '0;
                            r_y_a   <= '0;
                        end
                    end
                    ST_SWEEP, ST_FLUSH: begin
                        // Every SWEEP cycle has a valid address in stage a.
                        r_vld_b <= (r_state == ST_SWEEP);
                        r_x_b   <= r_x_a;
                        r_y_b   <= r_y_a;
                        r_plot  <= w_plot;
                        if (w_plot) begin
                            r_vga_x  <= 8'(r_x_b);
                            r_vga_y  <= 7'(r_y_b);
                            r_colour <= w_colour;
                        end
                        if (r_state == ST_SWEEP) begin
                            if (w_last) begin
                                r_state <= ST_FLUSH;
                            end else begin
                                r_addr <= r_addr + ADDR_W'(1);
                                if (r_x_a == c_X_MAX) begin
                                    r_x_a <= '0;
                                    r_y_a <= r_y_a + c_YW'(1);
                                end else begin
                                    r_x_a <= r_x_a + c_XW'(1);
                                end
                            end
                        end else if (!r_vld_b) begin
                            // Last cell has left the output stage.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_plot  <= 1'b0;
                        r_vld_b <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mem_addr   = r_addr;
    assign bus.VGA_X      = r_vga_x;
    assign bus.VGA_Y      = r_vga_y;
    assign bus.VGA_PLOT   = r_plot;
    assign bus.VGA_COLOUR = r_colour;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_grid_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grid_plotter
//  Description : Directed self-checking bench for grid_plotter on a 50x50
//                board: empty board, glider, row wrap, mid-sweep hold,
//                ignored starts, and reset mid-sweep.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_grid_plotter;
    localparam int c_COLS  = 50;
    localparam int c_CELLS = 2500;
`ifdef PLOT_DEAD_EN
    localparam bit c_DEAD = 1'b1;
`else
    localparam bit c_DEAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    grid_plotter_if #(.ADDR_W(12)) bus ();

    grid_plotter #(
        .X_SCREEN    (49),
        .Y_SCREEN    (49),
        .ADDR_W      (12),
        .ALIVE_COLOUR(3'b111),
        .DEAD_COLOUR (3'b000)
    ) dut (
        .CLOCK_50(clk),
        .rst     (rst),
        .bus     (bus)
    );

    // Synchronous board RAM model.
    logic ram [0:4095];
    always @(posedge clk) bus.mem_rdata <= ram[bus.mem_addr];

    // Edge counter: after edge E, cyc == E.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int busy_cnt, done_cnt, plot_cnt, hold_plots, hold_lo, hold_hi;
    int live_xy[$];
    int live_cyc[$];
    int total = 0;
    int bad   = 0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
        if (bus.VGA_PLOT) begin
            plot_cnt++;
            if (bus.VGA_COLOUR == 3'b111) begin
                live_xy.push_back(int'(bus.VGA_X) * 100 + int'(bus.VGA_Y));
                live_cyc.push_back(cyc);
            end
            if (cyc >= hold_lo && cyc <= hold_hi) hold_plots++;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 4096; i++) ram[i] = 1'b0;
    endtask

    task automatic set_cell(input int x, input int y);
        ram[y * c_COLS + x] = 1'b1;
    endtask

    function automatic int exp_plots(input int nlive);
        return c_DEAD ? c_CELLS : nlive;
    endfunction

    // One sweep: optional hold window (edges n+hold_at ..), optional start
    // pokes while busy and on the done edge. Returns start edge and latency.
    task automatic sweep(input int hold_at, input int hold_len, input bit poke,
                         output int n, output int lat);
        busy_cnt = 0; done_cnt = 0; plot_cnt = 0; hold_plots = 0;
        live_xy.delete();
        live_cyc.delete();
        hold_lo = 1; hold_hi = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = cyc;
        if (hold_len > 0) begin
            hold_lo = n + hold_at;
            hold_hi = n + hold_at + hold_len - 1;
        end
        lat = -1;
        for (int i = 0; i < 4000; i++) begin
            bus.hold  = (hold_len > 0) && (cyc + 1 >= hold_lo) && (cyc + 1 <= hold_hi);
            bus.start = poke && ((cyc + 1 == n + 500) ||
                                 (cyc + 1 == n + c_CELLS + 2 + hold_len));
            tick();
            if (bus.done) begin
                lat = cyc - n;
                break;
            end
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        repeat (4) tick();
    endtask

    int n, lat;
    int gx[5] = '{1, 2, 0, 1, 2};
    int gy[5] = '{0, 1, 2, 2, 2};

    task automatic load_glider();
        clear_ram();
        for (int i = 0; i < 5; i++) set_cell(gx[i], gy[i]);
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.hold = 1'b0;
        busy_cnt = 0; done_cnt = 0; plot_cnt = 0; hold_plots = 0;
        hold_lo = 1; hold_hi = 0;
        clear_ram();
        repeat (3) tick();
        rst = 1'b0;

        // Reset values
        check_eq("rst_busy",   int'(bus.busy),       0);
        check_eq("rst_done",   int'(bus.done),       0);
        check_eq("rst_plot",   int'(bus.VGA_PLOT),   0);
        check_eq("rst_addr",   int'(bus.mem_addr),   0);
        check_eq("rst_x",      int'(bus.VGA_X),      0);
        check_eq("rst_y",      int'(bus.VGA_Y),      0);
        check_eq("rst_colour", int'(bus.VGA_COLOUR), 0);

        // 1: empty board
        sweep(0, 0, 1'b0, n, lat);
        check_eq("empty_done_lat", lat, 2502);
        check_eq("empty_busy_cyc", busy_cnt, 2502);
        check_eq("empty_plots", plot_cnt, exp_plots(0));
        check_eq("empty_done_cnt", done_cnt, 1);

        // 2: glider, scan order and latency of first live cell (address 1)
        load_glider();
        sweep(0, 0, 1'b0, n, lat);
        check_eq("glider_plots", plot_cnt, exp_plots(5));
        check_eq("glider_live", live_xy.size(), 5);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("glider_xy%0d", i), (i < live_xy.size()) ? live_xy[i] : -1,
                     gx[i] * 100 + gy[i]);
        check_eq("glider_first_cyc", (live_cyc.size() > 0) ? live_cyc[0] - n : -1, 3);
        check_eq("glider_done_lat", lat, 2502);

        // 3: row wrap, addresses 49 and 50 plot on consecutive cycles
        clear_ram();
        set_cell(49, 0);
        set_cell(0, 1);
        sweep(0, 0, 1'b0, n, lat);
        check_eq("wrap_live", live_xy.size(), 2);
        check_eq("wrap_xy0", (live_xy.size() > 0) ? live_xy[0] : -1, 4900);
        check_eq("wrap_xy1", (live_xy.size() > 1) ? live_xy[1] : -1, 1);
        check_eq("wrap_cyc0", (live_cyc.size() > 0) ? live_cyc[0] - n : -1, 51);
        check_eq("wrap_cyc1", (live_cyc.size() > 1) ? live_cyc[1] - n : -1, 52);

        // 4: 10-cycle hold over edges n+100..n+109, cells at addresses 98..101
        clear_ram();
        set_cell(48, 1); set_cell(49, 1); set_cell(0, 2); set_cell(1, 2);
        sweep(100, 10, 1'b0, n, lat);
        check_eq("hold_done_lat", lat, 2512);
        check_eq("hold_busy_cyc", busy_cnt, 2512);
        check_eq("hold_plots_in_hold", hold_plots, 0);
        check_eq("hold_live", live_xy.size(), 4);
        check_eq("hold_xy0", (live_xy.size() > 0) ? live_xy[0] : -1, 4801);
        check_eq("hold_xy1", (live_xy.size() > 1) ? live_xy[1] : -1, 4901);
        check_eq("hold_xy2", (live_xy.size() > 2) ? live_xy[2] : -1, 2);
        check_eq("hold_xy3", (live_xy.size() > 3) ? live_xy[3] : -1, 102);
        check_eq("hold_cyc0", (live_cyc.size() > 0) ? live_cyc[0] - n : -1, 110);
        check_eq("hold_cyc3", (live_cyc.size() > 3) ? live_cyc[3] - n : -1, 113);

        // 5: hold in IDLE does nothing; starts while busy and on done ignored
        load_glider();
        bus.hold = 1'b1;
        repeat (3) tick();
        check_eq("idle_hold_busy", int'(bus.busy), 0);
        check_eq("idle_hold_plot", int'(bus.VGA_PLOT), 0);
        bus.hold = 1'b0;
        sweep(0, 0, 1'b1, n, lat);
        check_eq("poke_done_lat", lat, 2502);
        check_eq("poke_done_cnt", done_cnt, 1);
        check_eq("poke_busy_cyc", busy_cnt, 2502);
        check_eq("poke_busy_after", int'(bus.busy), 0);
        check_eq("poke_plots", plot_cnt, exp_plots(5));

        // 6: reset at edge n+1000 mid-sweep, then a clean restart
        load_glider();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = cyc;
        while (cyc < n + 999) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy",   int'(bus.busy),       0);
        check_eq("midrst_done",   int'(bus.done),       0);
        check_eq("midrst_plot",   int'(bus.VGA_PLOT),   0);
        check_eq("midrst_addr",   int'(bus.mem_addr),   0);
        check_eq("midrst_x",      int'(bus.VGA_X),      0);
        check_eq("midrst_y",      int'(bus.VGA_Y),      0);
        check_eq("midrst_colour", int'(bus.VGA_COLOUR), 0);
        done_cnt = 0;
        repeat (2600) tick();
        check_eq("midrst_no_done", done_cnt, 0);
        sweep(0, 0, 1'b0, n, lat);
        check_eq("restart_done_lat", lat, 2502);
        check_eq("restart_xy0", (live_xy.size() > 0) ? live_xy[0] : -1, 100);
        check_eq("restart_cyc0", (live_cyc.size() > 0) ? live_cyc[0] - n : -1, 3);
        check_eq("restart_live", live_xy.size(), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
